// File: rtl/dmem_pkg.sv
// Shared constants, arbiter state encoding and address legality for the data memory.
package dmem_pkg;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam logic [ADDR_W-1:0] MEM_BYTES = 64'd8192;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_t;

  // Legal means inside the memory and aligned to a 64-bit word.
  function automatic logic addr_legal(input logic [ADDR_W-1:0] addr);
    return (addr < MEM_BYTES) && (addr[2:0] == 3'b000);
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Request/response bundle between one requester and the data-memory arbiter.
interface dmem_req_if;
  import dmem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic              req_lock;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_write, req_lock, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_lock, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_rr_pick.sv
// Two-way round-robin chooser: on a tie the requester that was not served last wins.
module dmem_rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  assign gnt[0] = req[0] & (~req[1] | last);
  assign gnt[1] = req[1] & (~req[0] | ~last);

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between two requesters,
// with a bounded lock for read-modify-write sequences and a one-cycle response path.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int LOCK_MAX = 16
) (
  input  logic              clk,
  input  logic              reset,
  dmem_req_if.slave         m0,
  dmem_req_if.slave         m1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(LOCK_MAX) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

  arb_state_t        state_reg, state_next;
  logic              rr_last_reg, rr_last_next;
  logic [CNT_W-1:0]  lock_cnt_reg, lock_cnt_next;

  logic [1:0]        rsp_valid_reg;
  logic              rsp_err_reg;
  logic              rsp_rd_reg;

  logic [1:0]        req_valid;
  logic [1:0]        pick_gnt;
  logic [1:0]        gnt;
  logic              sel;
  logic              acc_any;
  logic              sel_write;
  logic              sel_lock;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              legal;

  assign req_valid = {m1.req_valid, m0.req_valid};

  dmem_rr_pick u_pick (
    .req  (req_valid),
    .last (rr_last_reg),
    .gnt  (pick_gnt)
  );

  // Grant is purely combinational; while locked only the owner may be served.
  always_comb begin
    gnt = 2'b00;
    if (!reset) begin
      case (state_reg)
        ARB:     gnt = pick_gnt;
        LOCK0:   gnt = {1'b0, req_valid[0]};
        LOCK1:   gnt = {req_valid[1], 1'b0};
        default: gnt = 2'b00;
      endcase
    end
  end

  assign sel       = gnt[1];
  assign acc_any   = |gnt;
  assign sel_write = sel ? m1.req_write : m0.req_write;
  assign sel_lock  = sel ? m1.req_lock  : m0.req_lock;
  assign sel_addr  = sel ? m1.req_addr  : m0.req_addr;
  assign sel_wdata = sel ? m1.req_wdata : m0.req_wdata;
  assign legal     = addr_legal(sel_addr);

  assign m0.req_ready = gnt[0];
  assign m1.req_ready = gnt[1];

  // Illegal beats are still accepted, but never strobe the memory.
  assign mem_addr  = acc_any ? sel_addr  : '0;
  assign mem_wdata = acc_any ? sel_wdata : '0;
  assign mem_write = acc_any &  sel_write & legal;
  assign mem_read  = acc_any & ~sel_write & legal;

  always_comb begin
    state_next    = state_reg;
    rr_last_next  = rr_last_reg;
    lock_cnt_next = lock_cnt_reg;
    case (state_reg)
      ARB: begin
        if (acc_any) begin
          rr_last_next = sel;
          if (sel_lock) begin
            state_next    = sel ? LOCK1 : LOCK0;
            lock_cnt_next = '0;
          end
        end
      end
      LOCK0, LOCK1: begin
        lock_cnt_next = lock_cnt_reg + CNT_W'(1);
        if (acc_any) begin
          rr_last_next = sel;
        end
        if (acc_any && !sel_lock) begin
          state_next    = ARB;
          lock_cnt_next = '0;
        end else if (lock_cnt_reg == CNT_LAST) begin
          // Owner held the lock too long: force release and let the other side in next.
          state_next    = ARB;
          rr_last_next  = (state_reg == LOCK1);
          lock_cnt_next = '0;
        end
      end
      default: begin
        state_next    = ARB;
        lock_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= ARB;
      rr_last_reg  <= 1'b1;
      lock_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      rr_last_reg  <= rr_last_next;
      lock_cnt_reg <= lock_cnt_next;
    end
  end

  // Response side: memory read data arrives the cycle after mem_read, alongside rsp_valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid_reg <= 2'b00;
      rsp_err_reg   <= 1'b0;
      rsp_rd_reg    <= 1'b0;
    end else begin
      rsp_valid_reg <= gnt;
      rsp_err_reg   <= acc_any & ~legal;
      rsp_rd_reg    <= acc_any & ~sel_write & legal;
    end
  end

  assign m0.rsp_valid = rsp_valid_reg[0];
  assign m1.rsp_valid = rsp_valid_reg[1];
  assign m0.rsp_err   = rsp_valid_reg[0] & rsp_err_reg;
  assign m1.rsp_err   = rsp_valid_reg[1] & rsp_err_reg;
  assign m0.rsp_rdata = (rsp_valid_reg[0] && rsp_rd_reg) ? mem_rdata : '0;
  assign m1.rsp_rdata = (rsp_valid_reg[1] && rsp_rd_reg) ? mem_rdata : '0;

endmodule
